// File: rtl/p2c_pkg.sv
`default_nettype none
// ============================================================================
// Package     : p2c_pkg
// Description : Shared constants, sector indices, FSM state type and the
//               sector-to-constant lookups for polar_to_cartesian_sweep.
//               SIN*_Q8 are Q0.8 sines of the beam centre angles and are
//               also used elsewhere in the locator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package p2c_pkg;

  localparam int R_W = 8;  // distance width
  localparam int K_W = 8;  // fractional width of the sine constants

  localparam logic [K_W-1:0] SIN15_Q8 = 8'd66;
  localparam logic [K_W-1:0] SIN45_Q8 = 8'd181;
  localparam logic [K_W-1:0] SIN75_Q8 = 8'd247;

  localparam logic [2:0] SEC_15  = 3'd0;
  localparam logic [2:0] SEC_45  = 3'd1;
  localparam logic [2:0] SEC_75  = 3'd2;
  localparam logic [2:0] SEC_105 = 3'd3;
  localparam logic [2:0] SEC_135 = 3'd4;
  localparam logic [2:0] SEC_165 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL_Y = 2'd1,
    ST_MUL_X = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // |sin| of the beam centre angle: constant for the y product.
  function automatic logic [K_W-1:0] sin_k(input logic [2:0] sec);
    case (sec)
      SEC_15, SEC_165: sin_k = SIN15_Q8;
      SEC_45, SEC_135: sin_k = SIN45_Q8;
      default:         sin_k = SIN75_Q8;
    endcase
  endfunction

  // |cos| of the beam centre angle: constant for the x magnitude.
  function automatic logic [K_W-1:0] cos_k(input logic [2:0] sec);
    case (sec)
      SEC_15, SEC_165: cos_k = SIN75_Q8;
      SEC_45, SEC_135: cos_k = SIN45_Q8;
      default:         cos_k = SIN15_Q8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_const_mult.sv
`default_nettype none
// ============================================================================
// Module      : serial_const_mult
// Description : LSB-first shift-add multiplier of an unsigned R_W-bit value
//               by a Q0.K_W constant. 'start' loads r and k and clears the
//               accumulator; R_W step cycles follow. On the last step 'done'
//               is high and 'product' carries the rounded result
//               (r*k + 2^(K_W-1)) >> K_W.
// Ports       : clock, reset_n (async, active-low), start, r, k in;
//               product, done out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_const_mult #(
  parameter int R_W = 8,
  parameter int K_W = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [R_W-1:0] r,
  input  logic [K_W-1:0] k,
  output logic [R_W-1:0] product,
  output logic           done
);

  localparam int ACC_W = R_W + K_W + 1;
  localparam int CNT_W = (R_W > 1) ? $clog2(R_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(R_W - 1);
  localparam logic [ACC_W-1:0] C_HALF = ACC_W'(1) << (K_W - 1);

  logic [R_W-1:0]     r_mplier;
  logic [R_W+K_W-1:0] r_mcand;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]   w_rounded;

  // The final add is folded combinationally into the product so the result
  // is usable on the same edge as the last step.
  assign w_acc_next = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_rounded  = w_acc_next + C_HALF;
  assign product    = w_rounded[K_W +: R_W];
  assign done       = r_busy && (r_cnt == C_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mplier <= r;
      r_mcand  <= {{R_W{1'b0}}, k};
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/polar_to_cartesian_sweep.sv
`default_nettype none
// ============================================================================
// Module      : polar_to_cartesian_sweep
// Description : Converts one (distance, sector) sample per handshake into a
//               Cartesian point. One serial constant multiplier is reused:
//               8 cycles for y = P(r, sin), then 8 cycles for
//               |x| = P(r, cos); x is negated after rounding for sectors
//               3..5. out_valid rises 16 edges after the accept edge.
// Ports       : clock, reset_n (async, active-low);
//               in_valid/in_ready/in_r/in_sector  - sample input;
//               out_valid/out_ready/out_x/out_y/out_sector - point output;
//               err_sector - sticky illegal-sector flag.
// Config      : P2C_ZERO_DROP_EN - when defined, legal samples with r==0
//               are consumed in IDLE without producing a point.
// Revision    : 1.0 - initial release
// ============================================================================
module polar_to_cartesian_sweep #(
  parameter int R_W = p2c_pkg::R_W,
  parameter int K_W = p2c_pkg::K_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [R_W-1:0]     in_r,
  input  logic [2:0]         in_sector,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [R_W:0] out_x,
  output logic [R_W-1:0]     out_y,
  output logic [2:0]         out_sector,
  output logic               err_sector
);

  import p2c_pkg::*;

  state_t         r_state;
  logic [R_W-1:0] r_r;
  logic [2:0]     r_sector;

  logic           w_legal;
  logic           w_drop;
  logic           w_start_y;
  logic           w_start_x;
  logic           w_mult_start;
  logic [R_W-1:0] w_mult_r;
  logic [K_W-1:0] w_mult_k;
  logic [R_W-1:0] w_product;
  logic           w_done;
  logic [R_W:0]   w_x_mag;

  assign w_legal = (in_sector <= SEC_165);

`ifdef P2C_ZERO_DROP_EN
  assign w_drop = (in_r == '0);
`else
  assign w_drop = 1'b0;
`endif

  // The y product starts straight from the input port on the accept edge;
  // the x product starts from the latched sample the edge y completes.
  assign w_start_y    = (r_state == ST_IDLE) && in_valid && w_legal && !w_drop;
  assign w_start_x    = (r_state == ST_MUL_Y) && w_done;
  assign w_mult_start = w_start_y || w_start_x;
  assign w_mult_r     = w_start_y ? in_r : r_r;
  assign w_mult_k     = w_start_y ? sin_k(in_sector) : cos_k(r_sector);
  assign w_x_mag      = {1'b0, w_product};

  serial_const_mult #(
    .R_W (R_W),
    .K_W (K_W)
  ) u_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_mult_start),
    .r       (w_mult_r),
    .k       (w_mult_k),
    .product (w_product),
    .done    (w_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_r        <= '0;
      r_sector   <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_sector <= '0;
      err_sector <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!w_legal) begin
              err_sector <= 1'b1;
            end else if (!w_drop) begin
              r_r      <= in_r;
              r_sector <= in_sector;
              in_ready <= 1'b0;
              r_state  <= ST_MUL_Y;
            end
          end
        end
        ST_MUL_Y: begin
          if (w_done) begin
            out_y   <= w_product;
            r_state <= ST_MUL_X;
          end
        end
        ST_MUL_X: begin
          if (w_done) begin
            // Negate after rounding keeps left/right beams symmetric.
            out_x      <= (r_sector >= SEC_105) ? -w_x_mag : w_x_mag;
            out_sector <= r_sector;
            out_valid  <= 1'b1;
            r_state    <= ST_OUT;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polar_to_cartesian_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_polar_to_cartesian_sweep
// Description : Self-checking bench. A cycle-count model derived from the
//               angle/rounding rules predicts in_ready, out_valid, the point
//               and err_sector; a compare process checks every cycle, and
//               directed vectors pin literal values and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polar_to_cartesian_sweep;

`ifdef P2C_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_r = '0;
  logic [2:0]        in_sector = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [8:0] out_x;
  logic [7:0]        out_y;
  logic [2:0]        out_sector;
  logic              err_sector;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  bit chk_en = 1'b0;

  polar_to_cartesian_sweep dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_sector  (in_sector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_sector (out_sector),
    .err_sector (err_sector)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: geometry + rounding ----------------
  function automatic int sin_q8(input int deg);
    int a;
    a = (deg > 90) ? 180 - deg : deg;
    case (a)
      15:      return 66;
      45:      return 181;
      default: return 247;
    endcase
  endfunction

  function automatic int prod(input int r, input int k);
    return (r * k + 128) / 256;
  endfunction

  function automatic int model_y(input int r, input int s);
    return prod(r, sin_q8(15 + 30 * s));
  endfunction

  function automatic int model_x(input int r, input int s);
    int a;
    a = 15 + 30 * s;
    if (a < 90) return prod(r, sin_q8(90 - a));
    return -prod(r, sin_q8(a - 90));
  endfunction

  // ---------------- model: timing ----------------
  bit m_busy, m_valid, m_err;
  int m_cnt, m_x, m_y, m_sec, p_x, p_y, p_sec;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 15) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_x     <= p_x;
        m_y     <= p_y;
        m_sec   <= p_sec;
      end
    end else if (in_valid) begin
      if (in_sector > 3'd5) begin
        m_err <= 1'b1;
      end else if (!(ZD && in_r == 8'd0)) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        p_y    <= model_y(int'(in_r), int'(in_sector));
        p_x    <= model_x(int'(in_r), int'(in_sector));
        p_sec  <= int'(in_sector);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && chk_en) begin
      check("in_ready", int'(in_ready), int'(!m_busy && !m_valid));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("err_sector", int'(err_sector), int'(m_err));
      if (m_valid) begin
        check("out_x", int'(out_x), m_x);
        check("out_y", int'(out_y), m_y);
        check("out_sector", int'(out_sector), m_sec);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int r, input int s);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    in_valid  = 1'b1;
    in_r      = 8'(r);
    in_sector = 3'(s);
    @(negedge clock);
    t0       = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int ex, input int ey, input int es);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("out_timeout", int'(out_valid), 1);
    check("latency", cyc - t0, 16);
    check("lit_x", int'(out_x), ex);
    check("lit_y", int'(out_y), ey);
    check("lit_sector", int'(out_sector), es);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("idle_ready", int'(in_ready), 1);
    check("idle_valid", int'(out_valid), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_sector", int'(out_sector), 0);
    check("rst_err", int'(err_sector), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals();
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);

    send(100, 0); wait_out(96, 26, 0);   take();
    send(100, 4); wait_out(-71, 71, 4);  take();
    send(255, 2); wait_out(66, 246, 2);  take();

    // Backpressure: point held, no new sample accepted.
    send(100, 3); wait_out(-26, 96, 3);
    in_valid = 1'b1; in_r = 8'd200; in_sector = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_x", int'(out_x), -26);
      check("bp_y", int'(out_y), 96);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    take();

    // Zero distance.
    if (ZD) begin
      send(0, 1);
      check("zd_ready", int'(in_ready), 1);
      check("zd_valid", int'(out_valid), 0);
      repeat (20) @(negedge clock);
    end else begin
      send(0, 1); wait_out(0, 0, 1); take();
    end

    // Illegal sector: sticky error, no output.
    send(50, 6);
    check("ill_err", int'(err_sector), 1);
    check("ill_valid", int'(out_valid), 0);
    repeat (20) @(negedge clock);
    send(100, 0); wait_out(96, 26, 0); take();
    check("err_sticky", int'(err_sector), 1);

    // Reset during MUL_X.
    send(100, 1);
    repeat (12) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    send(100, 5); wait_out(-96, 26, 5); take();

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
